// File: rtl/text_pkg.sv
// Shared constants and the 8x8 font table for the text pixel path.
// Glyph rows are packed row 0 first (bits 63:56), MSB of each row = leftmost pixel.
package text_pkg;

  localparam int RGB_W        = 16;
  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 8;
  localparam int GLYPH_COUNT  = 128;
  localparam int FONT_ADDR_W  = 10;
  localparam int PIPE_LATENCY = 3;

  typedef logic [RGB_W-1:0]       rgb565_t;
  typedef logic [GLYPH_W-1:0]     glyph_row_t;
  typedef logic [FONT_ADDR_W-1:0] font_addr_t;

  // Control codes 0x00-0x1F and space fall through to the all-zero default.
  function automatic logic [63:0] glyph(input logic [6:0] code);
    case (code)
      7'h21: glyph = 64'h30787830_30003000;  7'h22: glyph = 64'h6C6C6C00_00000000;
      7'h23: glyph = 64'h6C6CFE6C_FE6C6C00;  7'h24: glyph = 64'h307CC078_0CF83000;
      7'h25: glyph = 64'h00C6CC18_3066C600;  7'h26: glyph = 64'h386C3876_DCCC7600;
      7'h27: glyph = 64'h6060C000_00000000;  7'h28: glyph = 64'h18306060_60301800;
      7'h29: glyph = 64'h60301818_18306000;  7'h2A: glyph = 64'h00663CFF_3C660000;
      7'h2B: glyph = 64'h003030FC_30300000;  7'h2C: glyph = 64'h00000000_00303060;
      7'h2D: glyph = 64'h000000FC_00000000;  7'h2E: glyph = 64'h00000000_00303000;
      7'h2F: glyph = 64'h060C1830_60C08000;  7'h30: glyph = 64'h7CC6CEDE_F6E67C00;
      7'h31: glyph = 64'h30703030_3030FC00;  7'h32: glyph = 64'h78CC0C38_60CCFC00;
      7'h33: glyph = 64'h78CC0C38_0CCC7800;  7'h34: glyph = 64'h1C3C6CCC_FE0C1E00;
      7'h35: glyph = 64'hFCC0F80C_0CCC7800;  7'h36: glyph = 64'h3860C0F8_CCCC7800;
      7'h37: glyph = 64'hFCCC0C18_30303000;  7'h38: glyph = 64'h78CCCC78_CCCC7800;
      7'h39: glyph = 64'h78CCCC7C_0C187000;  7'h3A: glyph = 64'h00303000_00303000;
      7'h3B: glyph = 64'h00303000_00303060;  7'h3C: glyph = 64'h183060C0_60301800;
      7'h3D: glyph = 64'h0000FC00_00FC0000;  7'h3E: glyph = 64'h6030180C_18306000;
      7'h3F: glyph = 64'h78CC0C18_30003000;  7'h40: glyph = 64'h7CC6DEDE_DEC07800;
      7'h41: glyph = 64'h3078CCCC_FCCCCC00;  7'h42: glyph = 64'hFC66667C_6666FC00;
      7'h43: glyph = 64'h3C66C0C0_C0663C00;  7'h44: glyph = 64'hF86C6666_666CF800;
      7'h45: glyph = 64'hFE626878_6862FE00;  7'h46: glyph = 64'hFE626878_6860F000;
      7'h47: glyph = 64'h3C66C0C0_CE663E00;  7'h48: glyph = 64'hCCCCCCFC_CCCCCC00;
      7'h49: glyph = 64'h78303030_30307800;  7'h4A: glyph = 64'h1E0C0C0C_CCCC7800;
      7'h4B: glyph = 64'hE6666C78_6C66E600;  7'h4C: glyph = 64'hF0606060_6266FE00;
      7'h4D: glyph = 64'hC6EEFEFE_D6C6C600;  7'h4E: glyph = 64'hC6E6F6DE_CEC6C600;
      7'h4F: glyph = 64'h386CC6C6_C66C3800;  7'h50: glyph = 64'hFC66667C_6060F000;
      7'h51: glyph = 64'h78CCCCCC_DC781C00;  7'h52: glyph = 64'hFC66667C_6C66E600;
      7'h53: glyph = 64'h78CCE070_1CCC7800;  7'h54: glyph = 64'hFCB43030_30307800;
      7'h55: glyph = 64'hCCCCCCCC_CCCCFC00;  7'h56: glyph = 64'hCCCCCCCC_CC783000;
      7'h57: glyph = 64'hC6C6C6D6_FEEEC600;  7'h58: glyph = 64'hC6C66C38_386CC600;
      7'h59: glyph = 64'hCCCCCC78_30307800;  7'h5A: glyph = 64'hFEC68C18_3266FE00;
      7'h5B: glyph = 64'h78606060_60607800;  7'h5C: glyph = 64'hC0603018_0C060200;
      7'h5D: glyph = 64'h78181818_18187800;  7'h5E: glyph = 64'h10386CC6_00000000;
      7'h5F: glyph = 64'h00000000_000000FF;  7'h60: glyph = 64'h30301800_00000000;
      7'h61: glyph = 64'h0000780C_7CCC7600;  7'h62: glyph = 64'hE060607C_6666DC00;
      7'h63: glyph = 64'h000078CC_C0CC7800;  7'h64: glyph = 64'h1C0C0C7C_CCCC7600;
      7'h65: glyph = 64'h000078CC_FCC07800;  7'h66: glyph = 64'h386C60F0_6060F000;
      7'h67: glyph = 64'h000076CC_CC7C0CF8;  7'h68: glyph = 64'hE0606C76_6666E600;
      7'h69: glyph = 64'h30007030_30307800;  7'h6A: glyph = 64'h0C000C0C_0CCCCC78;
      7'h6B: glyph = 64'hE060666C_786CE600;  7'h6C: glyph = 64'h70303030_30307800;
      7'h6D: glyph = 64'h0000CCFE_FED6C600;  7'h6E: glyph = 64'h0000F8CC_CCCCCC00;
      7'h6F: glyph = 64'h000078CC_CCCC7800;  7'h70: glyph = 64'h0000DC66_667C60F0;
      7'h71: glyph = 64'h000076CC_CC7C0C1E;  7'h72: glyph = 64'h0000DC76_6660F000;
      7'h73: glyph = 64'h00007CC0_780CF800;  7'h74: glyph = 64'h10307C30_30341800;
      7'h75: glyph = 64'h0000CCCC_CCCC7600;  7'h76: glyph = 64'h0000CCCC_CC783000;
      7'h77: glyph = 64'h0000C6D6_FEFE6C00;  7'h78: glyph = 64'h0000C66C_386CC600;
      7'h79: glyph = 64'h0000CCCC_CC7C0CF8;  7'h7A: glyph = 64'h0000FC98_3064FC00;
      7'h7B: glyph = 64'h1C3030E0_30301C00;  7'h7C: glyph = 64'h18181800_18181800;
      7'h7D: glyph = 64'hE030301C_3030E000;  7'h7E: glyph = 64'h76DC0000_00000000;
      7'h7F: glyph = 64'hFFFFFFFF_FFFFFFFF;
      default: glyph = 64'h0;
    endcase
  endfunction

  // Address layout is {code[6:0], line[2:0]}.
  function automatic glyph_row_t font_row(input font_addr_t addr);
    logic [63:0] g;
    g = glyph(addr[9:3]);
    return g[8*(7-int'(addr[2:0])) +: 8];
  endfunction

endpackage

// File: rtl/text_pixel_renderer_if.sv
// Pixel-side bundle between the text buffer read port and the video mux.
interface text_pixel_renderer_if;
  import text_pkg::*;

  logic       pixelValid;
  logic       newScreen;
  logic [7:0] charCode;
  logic [2:0] asciiLineIndex;
  logic [2:0] asciiBitSelector;
  rgb565_t    foreGroundColor;
  rgb565_t    backGroundColor;
  logic       cursorVisible;
  rgb565_t    pixelColor;
  logic       pixelValidOut;

  modport master (
    output pixelValid, newScreen, charCode, asciiLineIndex, asciiBitSelector,
           foreGroundColor, backGroundColor, cursorVisible,
    input  pixelColor, pixelValidOut
  );

  modport slave (
    input  pixelValid, newScreen, charCode, asciiLineIndex, asciiBitSelector,
           foreGroundColor, backGroundColor, cursorVisible,
    output pixelColor, pixelValidOut
  );
endinterface

// File: rtl/text_font_rom.sv
// 1024x8 synchronous-read font ROM: the row appears the cycle after the address.
module text_font_rom
  import text_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  font_addr_t addr_i,
  output glyph_row_t row_o
);

  glyph_row_t row_q;

  // NOTE: only the read register is reset; the table is constant logic with no state to clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples values from before the edge.
      row_q <= font_row(addr_i);
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/text_pixel_renderer.sv
// Three-stage text-to-RGB565 renderer with a frame-counted cursor blinker.
module text_pixel_renderer
  import text_pkg::*;
#(
  parameter int unsigned blinkFrames   = 30,
  parameter bit          inverseEnable = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  text_pixel_renderer_if.slave pix
);

  localparam int CNT_W = (blinkFrames > 1) ? $clog2(blinkFrames) : 1;

  logic             valid_d1_q, valid_d2_q, valid_out_q;
  logic             cursor_d1_q, cursor_d2_q;
  logic             inv_q;
  rgb565_t          pixel_q, pixel_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  font_addr_t font_addr;
  glyph_row_t row;
  logic       glyph_bit, swap, blink_on;
  rgb565_t    fg, bg;

  // Bit 7 of the code is the inverse flag and never reaches the ROM.
  assign font_addr = {pix.charCode[6:0], pix.asciiLineIndex};

  text_font_rom u_font_rom (
    .clock  (clock),
    .reset  (reset),
    .addr_i (font_addr),
    .row_o  (row)
  );

  assign glyph_bit = row[pix.asciiBitSelector];
  assign swap      = inv_q & inverseEnable;
  assign fg        = swap ? pix.backGroundColor : pix.foreGroundColor;
  assign bg        = swap ? pix.foreGroundColor : pix.backGroundColor;
  assign blink_on  = phase_q | (blinkFrames == 0);

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pixel_d     = '0;

    if (pix.newScreen && (blinkFrames != 0)) begin
      if (blink_cnt_q == CNT_W'(blinkFrames - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end

    // Cursor wins over the glyph while the blink phase shows it.
    if (valid_d2_q) begin
      if (cursor_d2_q && blink_on) pixel_d = fg;
      else                         pixel_d = glyph_bit ? fg : bg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_d1_q  <= 1'b0;
      valid_d2_q  <= 1'b0;
      valid_out_q <= 1'b0;
      cursor_d1_q <= 1'b0;
      cursor_d2_q <= 1'b0;
      inv_q       <= 1'b0;
      pixel_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      valid_d1_q  <= pix.pixelValid;
      valid_d2_q  <= valid_d1_q;
      valid_out_q <= valid_d2_q;
      cursor_d1_q <= pix.cursorVisible;
      cursor_d2_q <= cursor_d1_q;
      inv_q       <= pix.charCode[7];
      pixel_q     <= pixel_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign pix.pixelColor    = pixel_q;
  assign pix.pixelValidOut = valid_out_q;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer: two parameterisations driven in lockstep, checked
// every cycle against a cycle-indexed behavioural model plus directed literals.
module tb_text_pixel_renderer;
  import text_pkg::*;

  localparam int MAXC = 1024;
  localparam int BF_A = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  text_pixel_renderer_if if_a ();
  text_pixel_renderer_if if_b ();

  text_pixel_renderer #(.blinkFrames(BF_A), .inverseEnable(1'b1)) dut_a (
    .clock (clock),
    .reset (reset),
    .pix   (if_a.slave)
  );

  text_pixel_renderer #(.blinkFrames(0), .inverseEnable(1'b0)) dut_b (
    .clock (clock),
    .reset (reset),
    .pix   (if_b.slave)
  );

  assign if_b.pixelValid       = if_a.pixelValid;
  assign if_b.newScreen        = if_a.newScreen;
  assign if_b.charCode         = if_a.charCode;
  assign if_b.asciiLineIndex   = if_a.asciiLineIndex;
  assign if_b.asciiBitSelector = if_a.asciiBitSelector;
  assign if_b.foreGroundColor  = if_a.foreGroundColor;
  assign if_b.backGroundColor  = if_a.backGroundColor;
  assign if_b.cursorVisible    = if_a.cursorVisible;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ns_total    = 0;

  // Raw pin history per cycle since reset release.
  logic       h_valid [MAXC];
  logic       h_cur   [MAXC];
  logic [7:0] h_code  [MAXC];
  logic [2:0] h_line  [MAXC];
  logic [2:0] h_bsel  [MAXC];
  rgb565_t    h_fore  [MAXC];
  rgb565_t    h_back  [MAXC];
  int         h_ns_before [MAXC];

  // Hand-computed expectations keyed by cycle.
  bit      lit_v  [MAXC];
  rgb565_t lit_a  [MAXC];
  rgb565_t lit_b  [MAXC];
  logic    lit_vo [MAXC];

  logic [7:0] a_rows [8] = '{8'h30, 8'h78, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'h00};

  logic [7:0] code_d1;
  logic [2:0] ln_d1, bs_d1, bs_d2;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Output at cycle k: valid/cursor from k-3, code/line from k-2, bit/colours/blink from k-1.
  function automatic void model(input int k, input int bf, input bit inv_en,
                                output rgb565_t px, output logic vo);
    logic [63:0] g;
    logic [7:0]  row, code;
    rgb565_t     fg, bg;
    bit          swap, on;
    int          frames;
    px = '0;
    vo = 1'b0;
    if (k >= 3) begin
      vo = h_valid[k-3];
      if (h_valid[k-3]) begin
        code   = h_code[k-2];
        g      = glyph(code[6:0]);
        row    = 8'(g >> (56 - 8*int'(h_line[k-2])));
        swap   = code[7] && inv_en;
        fg     = swap ? h_back[k-1] : h_fore[k-1];
        bg     = swap ? h_fore[k-1] : h_back[k-1];
        frames = h_ns_before[k-1];
        on     = (bf == 0) || (((frames / bf) % 2) == 0);
        if (h_cur[k-3] && on) px = fg;
        else                  px = row[h_bsel[k-1]] ? fg : bg;
      end
    end
  endfunction

  always @(negedge clock) begin
    rgb565_t ea, eb;
    logic    va, vb;
    if (reset) begin
      check("rst_px_a", if_a.pixelColor, 16'h0);
      check("rst_vo_a", 16'(if_a.pixelValidOut), 16'h0);
      check("rst_px_b", if_b.pixelColor, 16'h0);
      check("rst_vo_b", 16'(if_b.pixelValidOut), 16'h0);
      cyc      = 0;
      ns_total = 0;
      foreach (lit_v[i]) lit_v[i] = 1'b0;
    end else begin
      h_valid[cyc]     = if_a.pixelValid;
      h_cur[cyc]       = if_a.cursorVisible;
      h_code[cyc]      = if_a.charCode;
      h_line[cyc]      = if_a.asciiLineIndex;
      h_bsel[cyc]      = if_a.asciiBitSelector;
      h_fore[cyc]      = if_a.foreGroundColor;
      h_back[cyc]      = if_a.backGroundColor;
      h_ns_before[cyc] = ns_total;
      ns_total        += int'(if_a.newScreen);
      model(cyc, BF_A, 1'b1, ea, va);
      model(cyc, 0, 1'b0, eb, vb);
      check("px_a", if_a.pixelColor, ea);
      check("vo_a", 16'(if_a.pixelValidOut), 16'(va));
      check("px_b", if_b.pixelColor, eb);
      check("vo_b", 16'(if_b.pixelValidOut), 16'(vb));
      if (lit_v[cyc]) begin
        check("lit_px_a", if_a.pixelColor, lit_a[cyc]);
        check("lit_px_b", if_b.pixelColor, lit_b[cyc]);
        check("lit_vo", 16'(if_a.pixelValidOut), 16'(lit_vo[cyc]));
        check("model_a_vs_lit", ea, lit_a[cyc]);
        check("model_b_vs_lit", eb, lit_b[cyc]);
      end
      cyc++;
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget cyc=%0d got=overflow exp=<%0d", cyc, MAXC);
        $fatal(1);
      end
    end
  end

  // Drives one pixel transaction; code/line follow one cycle later, bit select two.
  task automatic send(input logic v, input logic cur, input logic [7:0] code,
                      input logic [2:0] ln, input logic [2:0] bs, input logic ns);
    if_a.pixelValid       = v;
    if_a.cursorVisible    = cur;
    if_a.newScreen        = ns;
    if_a.charCode         = code_d1;
    if_a.asciiLineIndex   = ln_d1;
    if_a.asciiBitSelector = bs_d2;
    bs_d2   = bs_d1;
    bs_d1   = bs;
    code_d1 = code;
    ln_d1   = ln;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic expect_px(input int dly, input rgb565_t a, input rgb565_t b, input logic vo);
    lit_v[cyc+dly]  = 1'b1;
    lit_a[cyc+dly]  = a;
    lit_b[cyc+dly]  = b;
    lit_vo[cyc+dly] = vo;
  endtask

  task automatic set_colors(input rgb565_t fore, input rgb565_t back);
    if_a.foreGroundColor = fore;
    if_a.backGroundColor = back;
  endtask

  // Holds pixelValid high through reset; returns at the start of cycle 0.
  task automatic do_reset(input int n);
    reset                 = 1'b1;
    if_a.pixelValid       = 1'b1;
    if_a.cursorVisible    = 1'b1;
    if_a.newScreen        = 1'b0;
    if_a.charCode         = 8'h7F;
    if_a.asciiLineIndex   = 3'd0;
    if_a.asciiBitSelector = 3'd7;
    code_d1 = 8'h00;
    ln_d1   = 3'd0;
    bs_d1   = 3'd0;
    bs_d2   = 3'd0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    expect_px(0, 16'h0, 16'h0, 1'b0);
    expect_px(1, 16'h0, 16'h0, 1'b0);
    expect_px(2, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    set_colors(16'hF800, 16'h001F);
    do_reset(3);

    // Full block, space, inverse full block, inverse space.
    expect_px(3, 16'hF800, 16'hF800, 1'b1); send(1'b1, 1'b0, 8'h7F, 3'd3, 3'd5, 1'b0);
    expect_px(3, 16'h001F, 16'h001F, 1'b1); send(1'b1, 1'b0, 8'h20, 3'd6, 3'd1, 1'b0);
    expect_px(3, 16'h001F, 16'hF800, 1'b1); send(1'b1, 1'b0, 8'hFF, 3'd0, 3'd7, 1'b0);
    expect_px(3, 16'hF800, 16'h001F, 1'b1); send(1'b1, 1'b0, 8'hA0, 3'd2, 3'd2, 1'b0);
    expect_px(3, 16'h0000, 16'h0000, 1'b0); send(1'b0, 1'b0, 8'h7F, 3'd4, 3'd4, 1'b0);
    idle(4);

    // Cursor lands at exactly t+3.
    set_colors(16'hFFFF, 16'h0000);
    expect_px(2, 16'h0000, 16'h0000, 1'b0);
    expect_px(3, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_px(4, 16'h0000, 16'h0000, 1'b0);
    send(1'b1, 1'b1, 8'h20, 3'd0, 3'd0, 1'b0);
    idle(4);

    // Two frames hide the cursor on the blinking instance.
    send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1); idle(1);
    send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1); idle(2);
    expect_px(3, 16'h0000, 16'hFFFF, 1'b1); send(1'b1, 1'b1, 8'h20, 3'd1, 3'd3, 1'b0);
    idle(3);

    // Two more frames, the second on top of a live pixel, bring it back.
    send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1); idle(1);
    expect_px(3, 16'hFFFF, 16'hFFFF, 1'b1); send(1'b1, 1'b0, 8'h7F, 3'd5, 3'd0, 1'b1);
    idle(3);
    expect_px(3, 16'hFFFF, 16'hFFFF, 1'b1); send(1'b1, 1'b1, 8'h20, 3'd2, 3'd2, 1'b0);
    idle(3);

    // 'A' swept row by row, left to right.
    set_colors(16'h07E0, 16'h0000);
    for (int ln = 0; ln < 8; ln++) begin
      for (int b = 7; b >= 0; b--) begin
        logic [7:0] r;
        r = a_rows[ln];
        expect_px(3, r[b] ? 16'h07E0 : 16'h0000, r[b] ? 16'h07E0 : 16'h0000, 1'b1);
        send(1'b1, 1'b0, 8'h41, 3'(ln), 3'(b), 1'b0);
      end
    end
    idle(4);

    // Hide the cursor, then reset mid-stream: pipeline clears and the cursor is shown again.
    send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1); idle(1);
    send(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1); idle(2);
    send(1'b1, 1'b0, 8'h7F, 3'd1, 3'd1, 1'b0);
    send(1'b1, 1'b1, 8'h7F, 3'd2, 3'd2, 1'b0);
    do_reset(2);
    expect_px(3, 16'h07E0, 16'h07E0, 1'b1); send(1'b1, 1'b1, 8'h20, 3'd0, 3'd0, 1'b0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
